// File: rtl/uart_pkg.sv
// Shared definitions for the host-side UART receiver: data width, default
// baud constants and the receiver FSM state encoding.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int SYS_CLK_HZ       = 100_000_000;
  localparam int BAUD             = 115200;
  localparam int CLKS_PER_BIT_DEF = SYS_CLK_HZ / BAUD;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } uart_state_t;

endpackage

// File: rtl/uart_rx_host_if.sv
// Host read/error bundle of the UART receiver.
// Handshake: rd_data is the show-ahead FIFO head and is meaningful while
// rd_valid is high; a byte is consumed on every rising clk edge where
// rd_valid and rd_en are both high (rd_en while rd_valid is low is ignored).
// The error flags are sticky until clr_err is sampled high.
interface uart_rx_host_if;
  import uart_pkg::*;

  logic                   rd_en;
  logic                   clr_err;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   rd_valid;
  logic                   overflow;
  logic                   frame_err;
  logic                   parity_err;

  // master: the consumer reading bytes out of the receiver
  modport master (
    output rd_en, clr_err,
    input  rd_data, rd_valid, overflow, frame_err, parity_err
  );

  // slave: the receiver itself
  modport slave (
    input  rd_en, clr_err,
    output rd_data, rd_valid, overflow, frame_err, parity_err
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO. Pointers carry one extra wrap bit so full and
// empty fall out of a compare of the MSBs. A pop on an empty FIFO is
// ignored; a push into a full FIFO only lands when a pop happens with it.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] push_data,
  input  logic                   pop,
  output logic [UART_DATA_W-1:0] pop_data,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic                   pop_ok;
  logic                   push_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes the contents by equating the pointers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks the output
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_host.sv
// Host-side UART receiver for the CPU Tx line. Synchronizes rx, times bit
// centres with a bit-period counter, shifts data in LSB first and pushes
// good bytes into a show-ahead FIFO. Sticky framing/parity/overflow flags.
// Build option: define UART_RX_PARITY_EN for 8E1 frames with a live
// parity_err; otherwise frames are 8N1 and parity_err is constant 0.
module uart_rx_host
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  uart_rx_host_if.slave host,
  output uart_state_t dbg_state
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic                   rx_meta;
  logic                   rxs;
  uart_state_t            state;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shreg;
  logic                   push_q;
  logic [UART_DATA_W-1:0] push_data;
  logic                   frame_set;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad;
  logic                   par_set;
  logic                   parity_flag;
`endif
  logic                   frame_flag;
  logic                   ovf_flag;
  logic                   ovf_set;
  logic                   fifo_push;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign dbg_state = state;

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Receiver FSM: bit-centre sampling, byte assembly, registered push/error pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      push_q    <= 1'b0;
      push_data <= '0;
      frame_set <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      par_set   <= 1'b0;
`endif
    end else begin
      push_q    <= 1'b0;
      frame_set <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_set   <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            // a start bit that has gone high again by mid-bit is a glitch
            state   <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[UART_DATA_W-1:1]};
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            // even parity: data bits plus parity bit hold an even number of ones
            par_bad <= rxs ^ (^shreg);
            state   <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rxs) begin
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                par_set <= 1'b1;
              end else begin
                push_q    <= 1'b1;
                push_data <= shreg;
              end
`else
              push_q    <= 1'b1;
              push_data <= shreg;
`endif
              // back to IDLE at mid-stop so a back-to-back start is caught
              state <= S_IDLE;
            end else begin
              frame_set <= 1'b1;
              state     <= S_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          // a held-low line (break) must not re-trigger start detection
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A full FIFO still takes the byte when the host pops in the same cycle
  assign fifo_push = push_q && (!fifo_full || host.rd_en);
  assign ovf_set   = push_q && fifo_full && !host.rd_en;

  // Sticky error flags; a clear wins over a set in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_flag  <= 1'b0;
      ovf_flag    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_flag <= 1'b0;
`endif
    end else if (host.clr_err) begin
      frame_flag  <= 1'b0;
      ovf_flag    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_flag <= 1'b0;
`endif
    end else begin
      if (frame_set) frame_flag  <= 1'b1;
      if (ovf_set)   ovf_flag    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      if (par_set)   parity_flag <= 1'b1;
`endif
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (host.rd_en),
    .pop_data  (host.rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign host.rd_valid  = !fifo_empty;
  assign host.overflow  = ovf_flag;
  assign host.frame_err = frame_flag;
`ifdef UART_RX_PARITY_EN
  assign host.parity_err = parity_flag;
`else
  assign host.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_host.sv
// Bench for uart_rx_host: drives serial frames bit by bit and compares the
// host-side outputs against a byte-queue model of what should be buffered
// and which sticky flags should be up. Parity cases run when the bench is
// built with UART_RX_PARITY_EN.
module tb_uart_rx_host;
  import uart_pkg::*;

  localparam int C     = 16;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx    = 1'b1;
  uart_state_t dbg_state;

  always #5 clk = ~clk;

  uart_rx_host_if hif ();

  uart_rx_host #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .host      (hif),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;
  logic       exp_frm = 1'b0;
  logic       exp_par = 1'b0;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_valid"}, 32'(hif.rd_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, "_head"}, 32'(hif.rd_data), 32'(exp_q[0]));
    check({tag, "_ovf"}, 32'(hif.overflow),   32'(exp_ovf));
    check({tag, "_frm"}, 32'(hif.frame_err),  32'(exp_frm));
    check({tag, "_par"}, 32'(hif.parity_err), 32'(exp_par));
  endtask

  // Reference behaviour of one whole frame: bad stop -> framing error,
  // bad parity -> parity error, otherwise buffered unless the FIFO is full.
  task automatic model_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    if (!stop)                     exp_frm = 1'b1;
    else if (par_flip)             exp_par = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else                           exp_ovf = 1'b1;
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (C) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    logic pbit;
    pbit = (^d) ^ par_flip;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(pbit);
`else
    if (pbit && par_flip) rx = 1'b1;
`endif
    drive_bit(stop);
  endtask

  task automatic read_one(input string tag);
    check({tag, "_rd"}, 32'(hif.rd_data), 32'(exp_q[0]));
    hif.rd_en = 1'b1;
    @(negedge clk);
    hif.rd_en = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic pulse_clr();
    hif.clr_err = 1'b1;
    @(negedge clk);
    hif.clr_err = 1'b0;
    exp_ovf = 1'b0;
    exp_frm = 1'b0;
    exp_par = 1'b0;
  endtask

  // Waits (bounded) until the FSM has just taken the stop sample.
  task automatic wait_stop_exit(output bit ok);
    int n;
    n = 0;
    while (dbg_state != S_STOP && n < 20 * C) begin @(negedge clk); n++; end
    while (dbg_state == S_STOP && n < 20 * C) begin @(negedge clk); n++; end
    ok = (n < 20 * C);
    if (!ok) check("stop_timeout", 32'(n), 32'(0));
  endtask

  // Push lands one clock after the stop sample
  task automatic watch_push();
    bit ok;
    wait_stop_exit(ok);
    if (ok) begin
      check("pre_push_valid", 32'(hif.rd_valid), 32'(0));
      @(negedge clk);
      check("post_push_valid", 32'(hif.rd_valid), 32'(1));
    end
  endtask

  // Pop exactly in the cycle the received byte is pushed into the full FIFO
  task automatic pop_on_push();
    bit ok;
    wait_stop_exit(ok);
    if (ok) begin
      check("simul_head", 32'(hif.rd_data), 32'(exp_q[0]));
      hif.rd_en = 1'b1;
      @(negedge clk);
      hif.rd_en = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    hif.rd_en   = 1'b0;
    hif.clr_err = 1'b0;
    @(negedge clk);
    idle(3);

    // reset state
    check("rst_data",  32'(hif.rd_data),    32'(0));
    check("rst_valid", 32'(hif.rd_valid),   32'(0));
    check("rst_ovf",   32'(hif.overflow),   32'(0));
    check("rst_frm",   32'(hif.frame_err),  32'(0));
    check("rst_par",   32'(hif.parity_err), 32'(0));
    check("rst_state", 32'(dbg_state),      32'(S_IDLE));
    rst_n = 1'b1;
    idle(4);

    // single byte with push timing
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      watch_push();
    join
    model_frame(8'hA5, 1'b1, 1'b0);
    idle(2);
    check_all("byte");
    read_one("byte");
    check_all("byte_drained");

    // start glitch
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(2 * C);
    check("glitch_state", 32'(dbg_state), 32'(S_IDLE));
    check_all("glitch");

    // framing error followed by a break, then a good byte
    send_frame(8'h3C, 1'b0, 1'b0);
    model_frame(8'h3C, 1'b0, 1'b0);
    idle(40);
    check("break_state", 32'(dbg_state), 32'(S_WAIT_HIGH));
    check_all("frame");
    rx = 1'b1;
    idle(C);
    send_frame(8'h11, 1'b1, 1'b0);
    model_frame(8'h11, 1'b1, 1'b0);
    idle(2);
    check_all("after_break");
    read_one("after_break");
    pulse_clr();
    check_all("frame_clr");

    // overflow: five bytes into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      model_frame(8'(i), 1'b1, 1'b0);
    end
    idle(2);
    check("ovf_depth", 32'(exp_q.size()), 32'(DEPTH));
    check_all("ovf");
    pulse_clr();
    check_all("ovf_clr");

    // full FIFO with a pop in the push cycle
    fork
      send_frame(8'h06, 1'b1, 1'b0);
      pop_on_push();
    join
    void'(exp_q.pop_front());
    exp_q.push_back(8'h06);
    idle(2);
    check_all("simul");
    while (exp_q.size() != 0) read_one("simul_drain");
    check_all("simul_empty");

`ifdef UART_RX_PARITY_EN
    // parity: wrong parity bit drops the byte, correct one delivers it
    send_frame(8'h07, 1'b1, 1'b1);
    model_frame(8'h07, 1'b1, 1'b1);
    idle(2);
    check_all("par_bad");
    send_frame(8'h07, 1'b1, 1'b0);
    model_frame(8'h07, 1'b1, 1'b0);
    idle(2);
    check_all("par_good");
    read_one("par_good");
    pulse_clr();
`endif

    // randomized frames, reads and clears
    for (int it = 0; it < 24; it++) begin
      logic [7:0] d;
      int         kind;
      logic       stop;
      logic       pflip;
      d     = 8'($urandom_range(0, 255));
      kind  = $urandom_range(0, 9);
      stop  = (kind != 0);
      pflip = 1'b0;
`ifdef UART_RX_PARITY_EN
      pflip = (kind == 1);
`endif
      send_frame(d, stop, pflip);
      model_frame(d, stop, pflip);
      if (!stop) begin
        idle(3);
        rx = 1'b1;
        idle(4);
      end else begin
        idle(2);
      end
      check_all("rand");
      for (int r = $urandom_range(0, 2); r > 0 && exp_q.size() != 0; r--) read_one("rand");
      if (kind == 9) begin
        pulse_clr();
        check_all("rand_clr");
      end
    end

    // reset mid-frame flushes buffered data and the partial byte
    while (exp_q.size() < 2) begin
      send_frame(8'h5A, 1'b1, 1'b0);
      model_frame(8'h5A, 1'b1, 1'b0);
    end
    idle(2);
    check_all("pre_rst");
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rx    = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_frm = 1'b0;
    exp_par = 1'b0;
    check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    check("midrst_data",  32'(hif.rd_data), 32'(0));
    check_all("midrst");
    idle(12 * C);
    check_all("midrst_later");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
